// File: rtl/mem_arb_pkg.sv
// Shared types and the grant rule for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int STRB_W = 4;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

  // Data wins unless fetch has waited through the full starvation allowance.
  function automatic arb_owner_t arb_grant(input logic if_req, input logic d_req,
                                           input logic if_starved);
    if (d_req && !(if_req && if_starved)) return OWN_D;
    return OWN_IF;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch and load/store; optional MEM_ARBITER_TIMEOUT_EN aborts stalled BUSY.
// Latency: request -> m_req next cycle, m_ack -> ready pulse one cycle later, back to IDLE the cycle after.
// Backpressure: requesters hold their level until ready; memory holds off by withholding m_ack.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_ready,
  output logic [WORD_W-1:0] if_rdata,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_ready,
  output logic [WORD_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [XLEN-1:0]   m_addr,
  output logic [WORD_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  input  logic              m_ack,
  input  logic [WORD_W-1:0] m_rdata,
  output logic              busy,
  output logic              err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t        state, state_d;
  arb_owner_t        owner, owner_d, grant;
  logic [SW-1:0]     starve_cnt, starve_d;
  logic              m_req_d, m_we_d, if_ready_d, d_ready_d, busy_d, err_d;
  logic [XLEN-1:0]   m_addr_d;
  logic [WORD_W-1:0] m_wdata_d, if_rdata_d, d_rdata_d;
  logic [STRB_W-1:0] m_wstrb_d;
  logic              d_req;
  logic              tmo_hit;

  assign d_req = d_rd | d_wr;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt;

  // Counts BUSY cycles; zero on the first BUSY cycle of every transaction.
  always_ff @(posedge clk) begin
    if (reset || state != BUSY) tmo_cnt <= '0;
    else                        tmo_cnt <= tmo_cnt + 1'b1;
  end
  assign tmo_hit = (state == BUSY) && !m_ack && (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state;
    owner_d    = owner;
    grant      = OWN_IF;
    starve_d   = starve_cnt;
    m_req_d    = m_req;
    m_we_d     = m_we;
    m_addr_d   = m_addr;
    m_wdata_d  = m_wdata;
    m_wstrb_d  = m_wstrb;
    if_rdata_d = if_rdata;
    d_rdata_d  = d_rdata;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    err_d      = 1'b0;

    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          grant   = arb_grant(if_req, d_req, starve_cnt == STARVE_MAX);
          owner_d = grant;
          state_d = BUSY;
          m_req_d = 1'b1;
          if (grant == OWN_D) begin
            m_we_d    = d_wr;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_wstrb_d = d_wstrb;
            if (!if_req)                      starve_d = '0;
            else if (starve_cnt != STARVE_MAX) starve_d = starve_cnt + 1'b1;
          end else begin
            m_we_d    = 1'b0;
            m_addr_d  = if_addr;
            m_wdata_d = '0;
            m_wstrb_d = '0;
            starve_d  = '0;
          end
        end
      end
      BUSY: begin
        if (m_ack || tmo_hit) begin
          state_d = RESP;
          m_req_d = 1'b0;
          err_d   = !m_ack;
          // An aborted transaction returns zero data alongside err.
          if (owner == OWN_IF) begin
            if_ready_d = 1'b1;
            if_rdata_d = m_ack ? m_rdata : '0;
          end else begin
            d_ready_d = 1'b1;
            d_rdata_d = m_ack ? m_rdata : '0;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      starve_cnt <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      starve_cnt <= starve_d;
      m_req      <= m_req_d;
      m_we       <= m_we_d;
      m_addr     <= m_addr_d;
      m_wdata    <= m_wdata_d;
      m_wstrb    <= m_wstrb_d;
      if_rdata   <= if_rdata_d;
      d_rdata    <= d_rdata_d;
      if_ready   <= if_ready_d;
      d_ready    <= d_ready_d;
      busy       <= busy_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; timeout scenario only when MEM_ARBITER_TIMEOUT_EN is defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_rd, d_wr;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        busy, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.XLEN(32), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [79:0] got;
    reset = 1'b1; if_req = 0; if_addr = 0; d_rd = 0; d_wr = 0; d_addr = 0;
    d_wdata = 0; d_wstrb = 0; m_ack = 0; m_rdata = 0;
    step(); step();
    reset = 1'b0;
    got = {m_req, m_we, if_ready, d_ready, err, busy, m_wstrb, 2'b00, m_addr, m_wdata};
    n_cmp++;
    if (got !== 80'h0) begin
      n_bad++; $display("FAIL reset_ctrl: got %h want 0", got);
    end
    n_cmp++;
    if ({if_rdata, d_rdata, dut.starve_cnt} !== '0) begin
      n_bad++; $display("FAIL reset_data: got %h %h %h want 0", if_rdata, d_rdata, dut.starve_cnt);
    end
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 32'h100;
    step();
    n_cmp++;
    if ({m_req, m_we, m_wstrb, busy, m_addr} !== {1'b1, 1'b0, 4'b0000, 1'b1, 32'h100}) begin
      n_bad++; $display("FAIL fetch_req: got req=%b we=%b strb=%b busy=%b addr=%h want 1 0 0000 1 100",
                        m_req, m_we, m_wstrb, busy, m_addr);
    end
    m_ack = 1; m_rdata = 32'h0050_0093;
    step();
    m_ack = 0; if_req = 0;
    n_cmp++;
    if ({if_ready, d_ready, m_req, if_rdata} !== {3'b100, 32'h0050_0093}) begin
      n_bad++; $display("FAIL fetch_resp: got ifr=%b dr=%b req=%b rdata=%h want 1 0 0 00500093",
                        if_ready, d_ready, m_req, if_rdata);
    end
    step();
    n_cmp++;
    if ({if_ready, busy} !== 2'b00) begin
      n_bad++; $display("FAIL fetch_idle: got ifr=%b busy=%b want 0 0", if_ready, busy);
    end
  endtask

  task automatic test_priority();
    if_req = 1; if_addr = 32'h104; d_rd = 1; d_addr = 32'h2000;
    step();
    n_cmp++;
    if ({m_addr, m_we, dut.starve_cnt} !== {32'h2000, 1'b0, 3'd1}) begin
      n_bad++; $display("FAIL prio_first: got addr=%h we=%b starve=%0d want 2000 0 1", m_addr, m_we, dut.starve_cnt);
    end
    m_ack = 1; m_rdata = 32'h1111_2222;
    step();
    m_ack = 0; d_rd = 0;
    n_cmp++;
    if ({d_ready, if_ready, d_rdata} !== {2'b10, 32'h1111_2222}) begin
      n_bad++; $display("FAIL prio_dresp: got dr=%b ifr=%b rdata=%h want 1 0 11112222", d_ready, if_ready, d_rdata);
    end
    step(); step();
    n_cmp++;
    if ({m_req, m_addr, dut.starve_cnt} !== {1'b1, 32'h104, 3'd0}) begin
      n_bad++; $display("FAIL prio_fetch: got req=%b addr=%h starve=%0d want 1 104 0", m_req, m_addr, dut.starve_cnt);
    end
    m_ack = 1; m_rdata = 32'hCAFE_0001;
    step();
    m_ack = 0; if_req = 0;
    n_cmp++;
    if ({if_ready, if_rdata} !== {1'b1, 32'hCAFE_0001}) begin
      n_bad++; $display("FAIL prio_fresp: got ifr=%b rdata=%h want 1 cafe0001", if_ready, if_rdata);
    end
    step();
  endtask

  task automatic test_starve();
    logic [31:0] exp_addr;
    logic [2:0]  exp_cnt;
    if_req = 1; if_addr = 32'h200; d_wr = 1; d_addr = 32'h3000; d_wdata = 32'h55; d_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      exp_addr = (i < 4) ? 32'h3000 : 32'h200;
      exp_cnt  = (i < 4) ? 3'(i + 1) : 3'd0;
      step();
      n_cmp++;
      if ({m_addr, m_we, dut.starve_cnt} !== {exp_addr, (i < 4), exp_cnt}) begin
        n_bad++; $display("FAIL starve_grant%0d: got addr=%h we=%b cnt=%0d want %h %b %0d",
                          i, m_addr, m_we, dut.starve_cnt, exp_addr, (i < 4), exp_cnt);
      end
      m_ack = 1;
      step();
      m_ack = 0;
      if (i == 4) begin
        if_req = 0; d_wr = 0;
      end
      n_cmp++;
      if ({d_ready, if_ready} !== ((i < 4) ? 2'b10 : 2'b01)) begin
        n_bad++; $display("FAIL starve_ready%0d: got dr=%b ifr=%b", i, d_ready, if_ready);
      end
      step();
    end
  endtask

  task automatic test_write_delay();
    d_wr = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011; m_rdata = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      n_cmp++;
      if ({m_req, m_we, m_wstrb, m_wdata, d_ready} !== {1'b1, 1'b1, 4'b0011, 32'hDEAD_BEEF, 1'b0}) begin
        n_bad++; $display("FAIL wr_hold%0d: got req=%b we=%b strb=%b wdata=%h dr=%b want 1 1 0011 deadbeef 0",
                          k, m_req, m_we, m_wstrb, m_wdata, d_ready);
      end
    end
    m_ack = 1;
    step();
    m_ack = 0; d_wr = 0;
    n_cmp++;
    if ({d_ready, m_req, err} !== 3'b100) begin
      n_bad++; $display("FAIL wr_ready: got dr=%b req=%b err=%b want 1 0 0", d_ready, m_req, err);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    d_rd = 1; d_addr = 32'h80;
    step();
    n_cmp++;
    if (m_req !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_busy: got req=%b want 1", m_req);
    end
    reset = 1; d_rd = 0;
    step();
    reset = 0;
    n_cmp++;
    if ({m_req, busy, d_ready, if_ready, err, m_addr, m_wstrb} !== '0) begin
      n_bad++; $display("FAIL rst_mid_out: got req=%b busy=%b dr=%b addr=%h want all 0", m_req, busy, d_ready, m_addr);
    end
    for (int c = 0; c < 4; c++) begin
      m_ack = (c == 0);
      step();
      if (d_ready || m_req) pulses++;
    end
    m_ack = 0;
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", pulses);
    end
    // A request still asserted across reset is arbitrated afresh.
    d_rd = 1; d_addr = 32'h84;
    step();
    reset = 1;
    step();
    reset = 0;
    step();
    n_cmp++;
    if ({m_req, m_addr} !== {1'b1, 32'h84}) begin
      n_bad++; $display("FAIL rst_rearb: got req=%b addr=%h want 1 84", m_req, m_addr);
    end
    m_ack = 1; m_rdata = 32'h77;
    step();
    m_ack = 0; d_rd = 0;
    step();
  endtask

`ifdef MEM_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    int hi = 0;
    d_rd = 1; d_addr = 32'h90;
    step();
    while (m_req && hi < 200) begin
      hi++;
      step();
    end
    d_rd = 0;
    n_cmp++;
    if (hi !== 64) begin
      n_bad++; $display("FAIL tmo_len: got %0d busy cycles want 64", hi);
    end
    n_cmp++;
    if ({d_ready, err, d_rdata} !== {2'b11, 32'h0}) begin
      n_bad++; $display("FAIL tmo_resp: got dr=%b err=%b rdata=%h want 1 1 0", d_ready, err, d_rdata);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_starve();
    test_write_delay();
    test_reset_mid();
`ifdef MEM_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
